// File: rtl/vec_alu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_alu_seq_if                                               |
// | Description : Control, operand and shared-ALU bundle of the vector-        |
// |               immediate sequencer. The slave side is the sequencer; the    |
// |               master side is the control unit / register file / ALU.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface vec_alu_seq_if #(
  parameter int NELEM = 5,
  parameter int WIDTH = 32
);
  // control handshake and operands
  logic                   start;
  logic [2:0]             op;
  logic [WIDTH-1:0]       imm32;
  logic [NELEM*WIDTH-1:0] a_vec;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [NELEM*WIDTH-1:0] result_vec;
  logic [3:0]             vflags;
  // shared scalar ALU
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [2:0]             alu_ctrl;
  logic [WIDTH-1:0]       alu_result;
  logic [3:0]             alu_flags;

  modport slave (
    input  start, op, imm32, a_vec, alu_result, alu_flags,
    output busy, done, err, result_vec, vflags, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output start, op, imm32, a_vec, alu_result, alu_flags,
    input  busy, done, err, result_vec, vflags, alu_a, alu_b, alu_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/vec_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_alu_seq                                                  |
// | Description : Executes one vector-immediate op (element[i] OP imm) over    |
// |               NELEM elements by feeding one element per cycle through a    |
// |               single shared scalar ALU. start/busy/done handshake.         |
// |               Optional macro VEC_ALU_SEQ_FLAGS_EN builds the aggregated    |
// |               {N_any, Z_all, C_any, V_any} flag accumulator; otherwise     |
// |               vflags is tied to zero and alu_flags is ignored.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vec_alu_seq #(
  parameter int NELEM = 5,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  vec_alu_seq_if.slave  bus
);

  localparam int                 c_idx_w    = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NELEM - 1);
  localparam logic [2:0]         c_op_max   = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_idx_w-1:0] r_idx;
  logic [WIDTH-1:0]   r_elem   [NELEM];
  logic [WIDTH-1:0]   r_result [NELEM];
  logic [WIDTH-1:0]   r_imm;
  logic [2:0]         r_op;
  logic               r_err;
  logic               w_accept;
  logic               w_illegal;

  // Next-state decode; start is only looked at in IDLE, so it is dropped while busy
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op <= c_op_max) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_illegal   = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_idx == c_last_idx) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand snapshot on acceptance, then one result element written per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_imm <= '0;
      r_op  <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < NELEM; i++) begin
        r_elem[i]   <= '0;
        r_result[i] <= '0;
      end
    end else begin
      r_err <= w_illegal;
      if (w_accept) begin
        r_idx <= '0;
        r_imm <= bus.imm32;
        r_op  <= bus.op;
        for (int i = 0; i < NELEM; i++) begin
          r_elem[i] <= bus.a_vec[i*WIDTH +: WIDTH];
        end
      end else if (r_state == S_RUN) begin
        r_result[r_idx] <= bus.alu_result;
        if (r_idx != c_last_idx) begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // ALU operands come straight from the snapshot so input changes during RUN are invisible
  assign bus.alu_a    = r_elem[r_idx];
  assign bus.alu_b    = r_imm;
  assign bus.alu_ctrl = r_op;

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
  assign bus.err  = r_err;

  for (genvar gi = 0; gi < NELEM; gi++) begin : g_pack
    assign bus.result_vec[gi*WIDTH +: WIDTH] = r_result[gi];
  end

`ifdef VEC_ALU_SEQ_FLAGS_EN
  logic [3:0] r_vflags;

  // Flag accumulator: N/C/V OR-reduced, Z AND-reduced, seeded with Z=1 on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vflags <= 4'b0000;
    end else if (w_accept) begin
      r_vflags <= 4'b0100;
    end else if (r_state == S_RUN) begin
      r_vflags <= {r_vflags[3] | bus.alu_flags[3],
                   r_vflags[2] & bus.alu_flags[2],
                   r_vflags[1] | bus.alu_flags[1],
                   r_vflags[0] | bus.alu_flags[0]};
    end
  end

  assign bus.vflags = r_vflags;
`else
  logic w_unused_flags;

  assign bus.vflags     = 4'b0000;
  assign w_unused_flags = ^bus.alu_flags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vec_alu_seq                                               |
// | Description : Directed self-checking bench for vec_alu_seq with a          |
// |               behavioural model of the shared scalar ALU.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vec_alu_seq;

  localparam int NELEM = 5;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_err = 0;
  int   n_chk = 0;
  int   lat;

  vec_alu_seq_if #(.NELEM(NELEM), .WIDTH(WIDTH)) bus ();

  vec_alu_seq #(.NELEM(NELEM), .WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared scalar ALU: add/sub/and/or, flags {N,Z,C,V}, C on sub means no borrow
  logic [32:0] m_sum;
  logic [31:0] m_res;
  logic        m_c;
  logic        m_v;
  always_comb begin
    m_sum = '0;
    m_res = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (bus.alu_ctrl)
      3'd0: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_res = m_sum[31:0];
        m_c   = m_sum[32];
        m_v   = (bus.alu_a[31] == bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
      end
      3'd1: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        m_res = m_sum[31:0];
        m_c   = m_sum[32];
        m_v   = (bus.alu_a[31] != bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
      end
      3'd2: m_res = bus.alu_a & bus.alu_b;
      3'd3: m_res = bus.alu_a | bus.alu_b;
      default: m_res = '0;
    endcase
  end
  assign bus.alu_result = m_res;
  assign bus.alu_flags  = {m_res[31], (m_res == 32'd0), m_c, m_v};

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_vf(input logic [3:0] v);
`ifdef VEC_ALU_SEQ_FLAGS_EN
    return v;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; returns cycles from acceptance edge until done is seen (bounded)
  task automatic run_op(input logic [2:0] o, input logic [31:0] im, input logic [159:0] av,
                        input bit hold, input bit scramble, output int l);
    bus.start = 1'b1;
    bus.op    = o;
    bus.imm32 = im;
    bus.a_vec = av;
    step();
    if (!hold) bus.start = 1'b0;
    l = 1;
    while (!bus.done && l < 20) begin
      if (scramble) begin
        for (int i = 0; i < NELEM; i++) bus.a_vec[i*WIDTH +: WIDTH] = $urandom;
        bus.imm32 = $urandom;
        bus.op    = 3'($urandom_range(0, 3));
      end
      step();
      l++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.imm32 = '0;
    bus.a_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_result", bus.result_vec, 0);
    check("rst_vflags", bus.vflags, 0);
    check("rst_alu_ops", {bus.alu_a, bus.alu_b, bus.alu_ctrl}, 0);
    reset = 1'b0;
    step();

    // add with wrap-around in the top element
    run_op(3'd0, 32'd1, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1, 32'd0}, 1'b0, 1'b0, lat);
    check("add_latency", lat, 6);
    check("add_busy_in_done", bus.busy, 1);
    check("add_result", bus.result_vec, {32'd0, 32'd4, 32'd3, 32'd2, 32'd1});
    check("add_vflags", bus.vflags, exp_vf(4'b0010));
    step();
    check("add_done_pulse", bus.done, 0);
    check("add_idle", bus.busy, 0);

    // sub to zero: Z_all and no-borrow carry
    run_op(3'd1, 32'd5, {5{32'd5}}, 1'b0, 1'b0, lat);
    check("sub_latency", lat, 6);
    check("sub_result", bus.result_vec, 0);
    check("sub_vflags", bus.vflags, exp_vf(4'b0110));
    step();

    // and, then or with start raised during DONE
    run_op(3'd2, 32'h0F0F0F0F, {5{32'hFFFF0000}}, 1'b0, 1'b0, lat);
    check("and_latency", lat, 6);
    check("and_result", bus.result_vec, {5{32'h0F0F0000}});
    check("and_vflags", bus.vflags, exp_vf(4'b0000));
    bus.start = 1'b1;
    bus.op    = 3'd3;
    step();
    check("start_ignored_in_done", bus.busy, 0);
    run_op(3'd3, 32'h0F0F0F0F, {5{32'hFFFF0000}}, 1'b0, 1'b0, lat);
    check("or_latency", lat, 6);
    check("or_result", bus.result_vec, {5{32'hFFFF0F0F}});
    check("or_vflags", bus.vflags, exp_vf(4'b1000));
    step();

    // illegal op
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.a_vec = '0;
    step();
    bus.start = 1'b0;
    check("illegal_err", bus.err, 1);
    check("illegal_busy", bus.busy, 0);
    step();
    check("illegal_err_pulse", bus.err, 0);
    check("illegal_result_kept", bus.result_vec, {5{32'hFFFF0F0F}});

    // start held through RUN: one operation only
    run_op(3'd0, 32'd7, {32'd50, 32'd40, 32'd30, 32'd20, 32'd10}, 1'b1, 1'b0, lat);
    check("hold_latency", lat, 6);
    check("hold_result", bus.result_vec, {32'd57, 32'd47, 32'd37, 32'd27, 32'd17});
    step();
    check("hold_single_op", bus.busy, 0);

    // reset at idx=2
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.imm32 = 32'd1;
    bus.a_vec = {5{32'd9}};
    step();
    bus.start = 1'b0;
    step();
    step();
    check("pre_reset_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_result", bus.result_vec, 0);
    check("midrst_done", bus.done, 0);
    step();
    step();
    check("midrst_no_done", bus.done, 0);
    reset = 1'b0;
    step();

    // operands scrambled every RUN cycle
    run_op(3'd0, 32'd16, {32'd500, 32'd400, 32'd300, 32'd200, 32'd100}, 1'b0, 1'b1, lat);
    check("snap_latency", lat, 6);
    check("snap_result", bus.result_vec, {32'd516, 32'd416, 32'd316, 32'd216, 32'd116});
    check("snap_vflags", bus.vflags, exp_vf(4'b0000));
    step();
    check("snap_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
Sequencer that executes one vector-immediate operation (element[i] OP imm32) over NELEM elements by time-multiplexing a single shared scalar alu. It is the low-area alternative to five parallel alu instances. It sits between the vector register read ports and the vector writeback path, issuing one element per cycle to the alu. It exposes a start/busy/done handshake to the control unit.

Parameters:
NELEM, 5, number of vector elements processed per operation (1..16)
WIDTH, 32, element and immediate width in bits

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request pulse/level; accepted only when busy=0
op  in  3  ALU operation: 0 add, 1 sub, 2 and, 3 or; 4-7 illegal
imm32  in  WIDTH  immediate operand applied to every element
a_vec  in  NELEM*WIDTH  packed source elements; element i at [i*WIDTH +: WIDTH]
alu_a  out  WIDTH  operand a to the shared alu
alu_b  out  WIDTH  operand b to the shared alu (captured imm32)
alu_ctrl  out  3  ALUControl to the shared alu (captured op)
alu_result  in  WIDTH  combinational result from the shared alu
alu_flags  in  4  {N,Z,C,V} from the shared alu
busy  out  1  high from the cycle after acceptance until the done cycle inclusive
done  out  1  one-cycle pulse; result_vec is valid in this cycle and afterwards
err  out  1  one-cycle pulse when start is seen in IDLE with an illegal op
result_vec  out  NELEM*WIDTH  packed results; element i at [i*WIDTH +: WIDTH]
vflags  out  4  aggregated flags (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, idx=0, busy=0, done=0, err=0, result_vec=0, vflags=0, captured op/imm/operands=0. alu_a/alu_b/alu_ctrl are derived from the captured registers, so they are 0 during reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 and op<=3: capture a_vec, imm32 and op into internal registers; set idx=0; go to RUN.
  - If start=1 and op>3: pulse err for 1 cycle; stay in IDLE; no capture.
  - Otherwise stay in IDLE.
- RUN:
  - alu_a = captured element[idx], alu_b = captured imm, alu_ctrl = captured op, all combinational from registers.
  - Each cycle, alu_result is written into result_vec element idx.
  - If idx==NELEM-1, go to DONE; otherwise idx increments by 1.
  - idx width is clog2(NELEM), minimum 1 bit.
- DONE: done=1 for exactly this cycle, then go to IDLE. start is ignored in DONE.
- Latency: start accepted at edge T; results are written at edges T+1..T+NELEM; done is high in cycle T+NELEM+1. For NELEM=5, done is high 6 cycles after acceptance.
- busy = (state != IDLE).
- start while busy: ignored, not queued. Input changes during RUN have no effect because operands were snapshotted.
- Back-to-back operation: start asserted in the cycle immediately after DONE (IDLE) is accepted. Throughput is one operation per NELEM+2 cycles.
- result_vec holds its value until the next accepted operation overwrites it element by element. Elements not yet written keep their previous values.
- Arithmetic: wrap-around modulo 2^WIDTH. The flag meaning is owned by alu; the sequencer does not reinterpret it.
- Reset mid-RUN: immediately returns to IDLE. result_vec is cleared to 0, busy=0, and no done pulse is issued.
- NELEM=1: RUN lasts exactly one cycle.

Optional Feature:
Macro VEC_ALU_SEQ_FLAGS_EN.
- Defined: vflags accumulates across the operation as {N_any, Z_all, C_any, V_any}.
  - N, C and V are OR-reduced over elements; Z is AND-reduced.
  - The accumulator initializes to 4'b0100 on acceptance and updates on each RUN cycle from alu_flags.
  - vflags is valid in the done cycle and held until the next acceptance.
- Undefined: vflags is tied to 4'b0000, and no accumulator logic or flag storage is built. alu_flags is left unused.

Test Plan:
- Reset, then start with op=0, imm32=1, elements {0,1,2,3,0xFFFFFFFF} -> busy high for 6 cycles; done pulses at the 6th cycle after acceptance; result_vec = {1,2,3,4,0}.
- op=1 (sub), imm32=5, elements {5,5,5,5,5} -> result_vec all 0. With FLAGS_EN, vflags=4'b0110 (Z_all, plus C from no-borrow).
- op=2 then op=3 back-to-back, imm32=0x0F0F0F0F, elements all 0xFFFF0000 -> the second start is accepted in the cycle after done; results are 0x0F0F0000, then 0xFFFF0F0F.
- start with op=5 in IDLE -> err pulses 1 cycle; busy stays 0; result_vec unchanged. start held high throughout RUN -> exactly one operation executes.
- Assert reset when idx=2 mid-RUN -> busy=0, result_vec=0 and state IDLE immediately; no done. A new start after reset release completes normally.
- Change a_vec and imm32 on every cycle during RUN -> results reflect only the values captured at acceptance.
